datacache_victim_ctrl: RTL

//  Sequencing controller for the L1 D-cache single-entry victim buffer.
//  - Accepts evicted lines from the D-cache and drives load/read of the external victim data array.
//  - Holds the victim tag, valid and take-pending state.
//  - Answers victim lookups from the D-cache.
//  - Writes dirty victims back to L2 over a write/resp handshake.
//  - Line data never passes through this block; array datain/dataout are wired at the cache top.

---
 rtl/datacache_victim_pkg.sv | 11 +
 rtl/datacache_victim_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/datacache_victim_pkg.sv
// Shared types for the L1 D-cache victim-buffer controller.
package datacache_victim_pkg;

  localparam int VC_ADDR_W = 32;

  typedef enum logic {
    VC_IDLE      = 1'b0,
    VC_WRITEBACK = 1'b1
  } vc_state_t;

endpackage

// File: rtl/datacache_victim_ctrl.sv
// Sequencing controller for the single-entry D-cache victim buffer: tag/valid
// tracking, lookup answers, array strobes and dirty-line writeback to L2.
module datacache_victim_ctrl
  import datacache_victim_pkg::*;
#(
  parameter int s_offset  = 5,
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 evict_valid,
  input  logic                 evict_dirty,
  input  logic [31:0]          evict_addr,
  output logic                 evict_ready,
  input  logic                 lookup_valid,
  input  logic [31:0]          lookup_addr,
  output logic                 lookup_hit,
  output logic                 vb_load,
  output logic                 vb_read,
  output logic                 mem_write,
  output logic [31:0]          mem_addr,
  input  logic                 mem_resp,
  output logic                 busy,
  output logic [cnt_width-1:0] wb_count,
  output logic                 o_dbg_state
);

  localparam int TAG_W = VC_ADDR_W - s_offset;

  // Handshake: an eviction transfers on a cycle where evict_valid && evict_ready;
  // evict_valid may be held and evict_ready may drop while waiting.

  vc_state_t            r_state, w_state_nx;
  logic                 r_valid, w_valid_nx;
  logic                 r_take_pend, w_take_pend_nx;
  logic [TAG_W-1:0]     r_tag, w_tag_nx;
  logic [cnt_width-1:0] r_wb_count, w_wb_count_nx;

  logic w_tag_match;

  assign w_tag_match = (lookup_addr[VC_ADDR_W-1:s_offset] == r_tag);

  // A line already claimed by the D-cache must not be handed out twice.
  assign lookup_hit  = lookup_valid && r_valid && !r_take_pend && w_tag_match;
  // The array forwards datain on load&&read, so a hit blocks a same-cycle load.
  assign evict_ready = (r_state == VC_IDLE) && !lookup_hit;
  assign vb_load     = evict_valid && evict_ready;
  assign vb_read     = lookup_hit || (r_state == VC_WRITEBACK);
  assign mem_write   = (r_state == VC_WRITEBACK);
  assign mem_addr    = {r_tag, {s_offset{1'b0}}};
  assign busy        = (r_state == VC_WRITEBACK);
  assign wb_count    = r_wb_count;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nx     = r_state;
    w_valid_nx     = r_valid;
    w_take_pend_nx = r_take_pend;
    w_tag_nx       = r_tag;
    w_wb_count_nx  = r_wb_count;

    unique case (r_state)
      VC_IDLE: begin
        if (vb_load) begin
          w_tag_nx       = evict_addr[VC_ADDR_W-1:s_offset];
          w_valid_nx     = 1'b1;
          w_take_pend_nx = 1'b0;
          w_state_nx     = evict_dirty ? VC_WRITEBACK : VC_IDLE;
        end else if (lookup_hit) begin
          w_valid_nx = 1'b0;
        end
      end
      VC_WRITEBACK: begin
        if (lookup_hit) begin
          w_take_pend_nx = 1'b1;
        end
        if (mem_resp) begin
          w_state_nx = VC_IDLE;
          if (!(&r_wb_count)) begin
            w_wb_count_nx = r_wb_count + {{(cnt_width-1){1'b0}}, 1'b1};
          end
          // A line taken during the writeback leaves the buffer once L2 has it.
          if (r_take_pend || lookup_hit) begin
            w_valid_nx = 1'b0;
          end
          w_take_pend_nx = 1'b0;
        end
      end
      default: w_state_nx = VC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= VC_IDLE;
      r_valid     <= 1'b0;
      r_take_pend <= 1'b0;
      r_tag       <= '0;
      r_wb_count  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_valid     <= w_valid_nx;
      r_take_pend <= w_take_pend_nx;
      r_tag       <= w_tag_nx;
      r_wb_count  <= w_wb_count_nx;
    end
  end

endmodule
